// File: rtl/bb_clk_gate_ctrl_if.sv
// Bundles the consumer-side request/busy/config signals with the gate controller's
// status outputs for one gating cell instance.
interface bb_clk_gate_ctrl_if #(
  parameter int IDLE_W = 8
);
  // req and busy are plain levels, sampled at every raw_clk edge: there is no
  // valid/ready transfer. ready=1 means the gated clock is running, so busy is legal.
  logic              req;
  logic              busy;
  logic [IDLE_W-1:0] cfg_idle;
  logic              active;
  logic              ready;
  logic [1:0]        state;
  logic [15:0]       gate_cnt;
  logic              err_busy;

  modport master (
    output req, busy, cfg_idle,
    input  active, ready, state, gate_cnt, err_busy
  );

  modport slave (
    input  req, busy, cfg_idle,
    output active, ready, state, gate_cnt, err_busy
  );
endinterface

// File: rtl/bb_clk_gate_ctrl.sv
// Clock-gate controller: drives the gating cell's active input, hides the cell's
// enable-pipeline latency on wake and shutdown, and applies idle hysteresis before gating.
module bb_clk_gate_ctrl #(
  parameter int GATE_LAT = 3,
  parameter int IDLE_W   = 8
) (
  input logic               raw_clk,
  input logic               rst_n,
  bb_clk_gate_ctrl_if.slave bus
);

  localparam int LAT_W = (GATE_LAT > 1) ? $clog2(GATE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(GATE_LAT - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [15:0]       gate_cnt_q;
  logic              active_q;
  logic              ready_q;
  logic              err_busy_q;

  logic idle_now;
  assign idle_now = !bus.req && !bus.busy;

  // active/ready are registered alongside the state so nothing from req/busy
  // reaches the gating cell combinationally.
  always_ff @(posedge raw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      lat_cnt_q  <= '0;
      idle_cnt_q <= '0;
      gate_cnt_q <= '0;
      active_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      if (bus.busy && (state_q != ST_ON)) begin
        err_busy_q <= 1'b1;
      end

      case (state_q)
        ST_OFF: begin
          if (bus.req) begin
            state_q   <= ST_WAKE;
            lat_cnt_q <= LAT_INIT;
            active_q  <= 1'b1;
            ready_q   <= 1'b0;
          end
        end

        ST_WAKE: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end else begin
            state_q    <= ST_ON;
            idle_cnt_q <= '0;
            active_q   <= 1'b1;
            ready_q    <= 1'b1;
          end
        end

        ST_ON: begin
          // cfg_idle is compared live; idle_cnt stops at the threshold so it cannot wrap.
          if (idle_now) begin
            if (idle_cnt_q >= bus.cfg_idle) begin
              state_q   <= ST_DRAIN;
              lat_cnt_q <= LAT_INIT;
              active_q  <= 1'b0;
              ready_q   <= 1'b0;
              if (gate_cnt_q != 16'hFFFF) begin
                gate_cnt_q <= gate_cnt_q + 16'd1;
              end
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end

        ST_DRAIN: begin
          // Enables are already in flight in the cell, so a new req waits for OFF.
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end else begin
            state_q <= ST_OFF;
          end
        end

        default: begin
          state_q  <= ST_OFF;
          active_q <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.active   = active_q;
  assign bus.ready    = ready_q;
  assign bus.state    = state_q;
  assign bus.gate_cnt = gate_cnt_q;
  assign bus.err_busy = err_busy_q;

endmodule

// File: tb/tb_bb_clk_gate_ctrl.sv
// Self-checking bench for bb_clk_gate_ctrl: directed scenarios plus random req/busy
// traffic, each compared against a timestamp-based reference model.
module tb_bb_clk_gate_ctrl;

  localparam int GATE_LAT = 3;
  localparam int IDLE_W   = 8;

  logic raw_clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  bb_clk_gate_ctrl_if #(.IDLE_W(IDLE_W)) bus_if ();

  bb_clk_gate_ctrl #(
    .GATE_LAT(GATE_LAT),
    .IDLE_W  (IDLE_W)
  ) dut (
    .raw_clk(raw_clk),
    .rst_n  (rst_n),
    .bus    (bus_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Phases: 0 off, 1 waking, 2 on, 3 draining. Wake/drain end at an absolute edge index.
  int m_edge;
  int m_mode;
  int m_exit_edge;
  int m_idle_run;
  int m_gcnt;
  bit m_err;

  function automatic void model_reset();
    m_mode     = 0;
    m_exit_edge = 0;
    m_idle_run = 0;
    m_gcnt     = 0;
    m_err      = 1'b0;
  endfunction

  function automatic void model_edge(bit req, bit busy, int cfg);
    m_edge++;
    if (busy && m_mode != 2) m_err = 1'b1;
    case (m_mode)
      0: if (req) begin m_mode = 1; m_exit_edge = m_edge + GATE_LAT; end
      1: if (m_edge == m_exit_edge) begin m_mode = 2; m_idle_run = 0; end
      2: begin
        if (!req && !busy) begin
          if (m_idle_run >= cfg) begin
            m_mode = 3;
            m_exit_edge = m_edge + GATE_LAT;
            if (m_gcnt < 65535) m_gcnt++;
          end else begin
            m_idle_run++;
          end
        end else begin
          m_idle_run = 0;
        end
      end
      default: if (m_edge == m_exit_edge) m_mode = 0;
    endcase
  endfunction

  // {state, active, ready, err_busy, gate_cnt}
  function automatic logic [20:0] model_vec();
    return {2'(m_mode), (m_mode == 1 || m_mode == 2), (m_mode == 2), m_err, 16'(m_gcnt)};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus_if.state, bus_if.active, bus_if.ready, bus_if.err_busy, bus_if.gate_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge(bus_if.req, bus_if.busy, int'(bus_if.cfg_idle));
    @(posedge raw_clk);
    @(negedge raw_clk);
  endtask

  task automatic drive(bit req, bit busy);
    bus_if.req  = req;
    bus_if.busy = busy;
  endtask

  task automatic do_reset();
    @(negedge raw_clk);
    rst_n = 1'b0;
    drive(0, 0);
    model_reset();
    repeat (2) @(negedge raw_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [20:0] exp_v;
    rst_n = 1'b0;
    drive(0, 0);
    bus_if.cfg_idle = 8'd4;
    model_reset();
    repeat (3) @(negedge raw_clk);
    n_checks++;
    if (dut_vec() !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_hold: got %h required %h", dut_vec(), 21'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_v = model_vec();
      n_checks++;
      if (dut_vec() !== exp_v || exp_v !== 21'd0) begin
        n_errors++;
        $display("FAIL reset_idle cyc%0d: got %h required %h", i, dut_vec(), 21'd0);
      end
    end
  endtask

  task automatic test_wake();
    logic [20:0] exp_v;
    int wake_cycles;
    int first_ready;
    wake_cycles = 0;
    first_ready = -1;
    bus_if.cfg_idle = 8'd4;
    drive(1, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) drive(0, 0);
      exp_v = model_vec();
      n_checks++;
      if (dut_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL wake cyc%0d: got %h required %h", i, dut_vec(), exp_v);
      end
      if (bus_if.state == 2'd1) wake_cycles++;
      if (bus_if.ready && first_ready < 0) first_ready = i;
    end
    n_checks++;
    if (wake_cycles != GATE_LAT || first_ready != GATE_LAT) begin
      n_errors++;
      $display("FAIL wake_latency: got wake=%0d ready_at=%0d required wake=%0d ready_at=%0d",
               wake_cycles, first_ready, GATE_LAT, GATE_LAT);
    end
  endtask

  // Brings the block to ON with req held, leaves req high.
  task automatic go_on();
    drive(1, 0);
    for (int i = 0; i < GATE_LAT + 1; i++) tick();
  endtask

  task automatic test_hysteresis();
    int gc0;
    int n;
    logic [20:0] exp_v;
    for (int pass = 0; pass < 2; pass++) begin
      bus_if.cfg_idle = 8'd4;
      go_on();
      gc0 = m_gcnt;
      drive(0, 0);
      n = 0;
      while (n < 50) begin
        if (pass == 1 && n == 2) drive(0, 1);
        else drive(0, 0);
        tick();
        n++;
        exp_v = model_vec();
        n_checks++;
        if (dut_vec() !== exp_v) begin
          n_errors++;
          $display("FAIL hyst p%0d cyc%0d: got %h required %h", pass, n, dut_vec(), exp_v);
        end
        if (!bus_if.ready) break;
      end
      n_checks++;
      if (n != (pass == 0 ? 5 : 8) || int'(bus_if.gate_cnt) != gc0 + 1) begin
        n_errors++;
        $display("FAIL hyst_len p%0d: got edges=%0d gate_cnt=%0d required edges=%0d gate_cnt=%0d",
                 pass, n, bus_if.gate_cnt, (pass == 0 ? 5 : 8), gc0 + 1);
      end
      for (int i = 0; i < GATE_LAT + 1; i++) tick();
    end
  endtask

  task automatic test_idle_zero();
    logic [1:0] exp_s[4];
    exp_s = '{2'd3, 2'd3, 2'd3, 2'd0};
    bus_if.cfg_idle = 8'd0;
    go_on();
    drive(0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus_if.state !== exp_s[i] || dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL idle_zero cyc%0d: got state=%0d vec=%h required state=%0d vec=%h",
                 i, bus_if.state, dut_vec(), exp_s[i], model_vec());
      end
    end
  endtask

  task automatic test_req_during_drain();
    logic [1:0] exp_s[5];
    exp_s = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
    bus_if.cfg_idle = 8'd0;
    go_on();
    drive(0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) drive(1, 0);
      n_checks++;
      if (bus_if.state !== exp_s[i] || bus_if.err_busy !== 1'b0 || dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL req_drain cyc%0d: got state=%0d err=%0b required state=%0d err=0",
                 i, bus_if.state, bus_if.err_busy, exp_s[i]);
      end
    end
    drive(0, 0);
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_error_reset();
    do_reset();
    drive(0, 1);
    tick();
    drive(0, 0);
    n_checks++;
    if (bus_if.err_busy !== 1'b1 || bus_if.state !== 2'd0) begin
      n_errors++;
      $display("FAIL err_off: got err=%0b state=%0d required err=1 state=0", bus_if.err_busy, bus_if.state);
    end
    bus_if.cfg_idle = 8'd2;
    go_on();
    drive(1, 1);
    tick();
    n_checks++;
    if (bus_if.err_busy !== 1'b1 || dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL err_sticky: got %h required %h", dut_vec(), model_vec());
    end
    drive(0, 0);
    for (int i = 0; i < 10; i++) tick();
    drive(1, 0);
    tick();
    tick();
    n_checks++;
    if (bus_if.state !== 2'd1 || bus_if.active !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_async_wake: got state=%0d active=%0b required state=1 active=1",
               bus_if.state, bus_if.active);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 21'd0) begin
      n_errors++;
      $display("FAIL async_reset: got %h required %h", dut_vec(), 21'd0);
    end
    drive(0, 0);
    @(negedge raw_clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_errors++;
      $display("FAIL post_reset: got %h required %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) bus_if.cfg_idle = 8'($urandom_range(0, 6));
      bus_if.req  = ($urandom_range(0, 3) == 0);
      bus_if.busy = (m_mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      tick();
      exp_v = model_vec();
      n_checks++;
      if (dut_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL random cyc%0d: got %h required %h", i, dut_vec(), exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    m_edge   = 0;
    test_reset();
    test_wake();
    test_hysteresis();
    test_idle_zero();
    test_req_during_drain();
    test_error_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
